// File: rtl/pokey_serout_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : pokey_serout_tx_if
// Purpose : Bus bundle between the POKEY core and the SEROUT transmitter.
//           Optional force-break wire present with POKEY_SEROUT_BREAK_EN.
// Rev     : 1.0  initial release
// ============================================================================
interface pokey_serout_tx_if;
    logic       enp;
    logic       bit_tick;
    logic       wr;
    logic [7:0] din;
`ifdef POKEY_SEROUT_BREAK_EN
    logic       force_break;
`endif
    logic       sout;
    logic       need_data;
    logic       done;
    logic       busy;

    modport master (
        output enp, bit_tick, wr, din,
`ifdef POKEY_SEROUT_BREAK_EN
        output force_break,
`endif
        input  sout, need_data, done, busy
    );

    modport slave (
        input  enp, bit_tick, wr, din,
`ifdef POKEY_SEROUT_BREAK_EN
        input  force_break,
`endif
        output sout, need_data, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/pokey_serout_tx.sv
`default_nettype none
// ============================================================================
// Module  : pokey_serout_tx
// Purpose : POKEY SEROUT transmitter: holding register, 8N1 shifter, SEROR /
//           SEROC interrupt sources. Macro POKEY_SEROUT_BREAK_EN adds break.
// Rev     : 1.0  initial release
// ============================================================================
module pokey_serout_tx (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pokey_serout_tx_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0] state_q,     state_d;
    logic [7:0] hold_q,      hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shreg_q,     shreg_d;
    logic [2:0] cnt_q,       cnt_d;
    logic       sout_fsm_q,  sout_fsm_d;
    logic       need_data_q, need_data_d;
    logic       done_q,      done_d;
    logic       busy_q,      busy_d;

    logic w_tick;
    logic w_wr;
    logic w_xfer;

    assign w_tick = bus.enp & bus.bit_tick;
    assign w_wr   = bus.enp & bus.wr;

    // State register: everything advances only on enp-qualified edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= c_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shreg_q     <= 8'h00;
            cnt_q       <= 3'd0;
            sout_fsm_q  <= 1'b1;
            need_data_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
        end else if (bus.enp) begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            sout_fsm_q  <= sout_fsm_d;
            need_data_q <= need_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        sout_fsm_d  = sout_fsm_q;
        w_xfer      = 1'b0;

        if (w_tick) begin
            case (state_q)
                c_IDLE: begin
                    w_xfer = hold_full_q;
                end
                c_START: begin
                    state_d    = c_DATA;
                    sout_fsm_d = shreg_q[0];
                    shreg_d    = {1'b0, shreg_q[7:1]};
                    cnt_d      = 3'd0;
                end
                c_DATA: begin
                    if (cnt_q == 3'd7) begin
                        state_d    = c_STOP;
                        sout_fsm_d = 1'b1;
                    end else begin
                        sout_fsm_d = shreg_q[0];
                        shreg_d    = {1'b0, shreg_q[7:1]};
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                default: begin
                    if (hold_full_q) begin
                        w_xfer = 1'b1;
                    end else begin
                        state_d    = c_IDLE;
                        sout_fsm_d = 1'b1;
                    end
                end
            endcase
        end

        // Transfer uses the old holding byte; a simultaneous write refills it.
        if (w_xfer) begin
            shreg_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = c_START;
            sout_fsm_d  = 1'b0;
        end
        if (w_wr) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        need_data_d = w_xfer;
        done_d      = (state_d == c_IDLE) && !hold_full_d;
        busy_d      = (state_d != c_IDLE);
    end

`ifdef POKEY_SEROUT_BREAK_EN
    logic sout_q, sout_d;

    // Break only masks the line; the frame engine keeps running underneath.
    always_comb begin
        sout_d = bus.force_break ? 1'b0 : sout_fsm_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sout_q <= 1'b1;
        end else if (bus.enp) begin
            sout_q <= sout_d;
        end
    end
`endif

    // Output logic.
    always_comb begin
`ifdef POKEY_SEROUT_BREAK_EN
        bus.sout      = sout_q;
`else
        bus.sout      = sout_fsm_q;
`endif
        bus.need_data = need_data_q;
        bus.done      = done_q;
        bus.busy      = busy_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pokey_serout_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pokey_serout_tx
// Purpose : Self-checking bench; a line receiver rebuilds frames into a queue
//           that is matched against bytes queued by each scenario.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pokey_serout_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pokey_serout_tx_if bus_if();

    pokey_serout_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    int         nd_count = 0;
    int         nd_bad = 0;
    logic       mon_tk, mon_en;

    // Line receiver: samples sout just after every enp-qualified tick edge.
    always @(posedge clk) begin
        mon_tk = rst_n && bus_if.enp && bus_if.bit_tick;
        mon_en = rst_n && bus_if.enp;
        #1;
        if (!rst_n) begin
            rx_cnt = 0;
        end else begin
            if (mon_en && bus_if.need_data) begin
                nd_count++;
                if (!(mon_tk && rx_cnt == 0 && bus_if.sout == 1'b0)) nd_bad++;
            end
            if (mon_tk) begin
                if (rx_cnt == 0) begin
                    if (bus_if.sout == 1'b0) rx_cnt = 1;
                end else if (rx_cnt <= 8) begin
                    rx_byte[rx_cnt-1] = bus_if.sout;
                    rx_cnt++;
                end else begin
                    rx_q.push_back({bus_if.sout, rx_byte});
                    rx_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        repeat (2) @(negedge clk);
        bus_if.bit_tick = 1'b1;
        @(negedge clk);
        bus_if.bit_tick = 1'b0;
    endtask

    task automatic tick_wr(input logic [7:0] b);
        repeat (2) @(negedge clk);
        bus_if.bit_tick = 1'b1;
        bus_if.wr       = 1'b1;
        bus_if.din      = b;
        @(negedge clk);
        bus_if.bit_tick = 1'b0;
        bus_if.wr       = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_if.wr  = 1'b1;
        bus_if.din = b;
        @(negedge clk);
        bus_if.wr  = 1'b0;
    endtask

    task automatic test_reset();
        int nd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.sout, bus_if.done, bus_if.busy, bus_if.need_data} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=1100",
                     {bus_if.sout, bus_if.done, bus_if.busy, bus_if.need_data});
        end
        rst_n = 1'b1;
        nd0 = nd_count;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if ({bus_if.sout, bus_if.done, bus_if.busy} !== 3'b110) begin
                errors++;
                $display("FAIL idle_tick%0d got=%b exp=110", i, {bus_if.sout, bus_if.done, bus_if.busy});
            end
        end
        checks++;
        if (nd_count - nd0 != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL idle_activity got nd=%0d frames=%0d exp nd=0 frames=0", nd_count - nd0, rx_q.size());
        end
    endtask

    task automatic test_single();
        logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int nd0;
        logic [8:0] want, got;
        nd0 = nd_count;
        exp_q.push_back({1'b1, 8'hA5});
        write_byte(8'hA5);
        checks++;
        if ({bus_if.sout, bus_if.done, bus_if.busy} !== 3'b100) begin
            errors++;
            $display("FAIL single_after_write got=%b exp=100", {bus_if.sout, bus_if.done, bus_if.busy});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus_if.sout !== exp_bits[i]) begin
                errors++;
                $display("FAIL single_bit%0d got=%b exp=%b", i, bus_if.sout, exp_bits[i]);
            end
            if (i == 0) begin
                checks++;
                if ({bus_if.need_data, bus_if.busy, bus_if.done} !== 3'b110) begin
                    errors++;
                    $display("FAIL single_start_flags got=%b exp=110",
                             {bus_if.need_data, bus_if.busy, bus_if.done});
                end
            end
        end
        tick();
        checks++;
        if ({bus_if.sout, bus_if.done, bus_if.busy} !== 3'b110) begin
            errors++;
            $display("FAIL single_end got=%b exp=110", {bus_if.sout, bus_if.done, bus_if.busy});
        end
        checks++;
        if (nd_count - nd0 != 1) begin
            errors++;
            $display("FAIL single_nd_count got=%0d exp=1", nd_count - nd0);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL single_frame got=none exp=%h", want);
            end else begin
                got = rx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL single_frame got=%h exp=%h", got, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] want, got;
        exp_q.push_back({1'b1, 8'h00});
        exp_q.push_back({1'b1, 8'hFF});
        write_byte(8'h00);
        tick();
        checks++;
        if ({bus_if.need_data, bus_if.sout} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_first_start got=%b exp=10", {bus_if.need_data, bus_if.sout});
        end
        write_byte(8'hFF);
        for (int i = 1; i < 20; i++) begin
            tick();
            checks++;
            if (bus_if.done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_done_tick%0d got=%b exp=0", i, bus_if.done);
            end
            if (i == 10) begin
                checks++;
                if ({bus_if.sout, bus_if.need_data, bus_if.busy} !== 3'b011) begin
                    errors++;
                    $display("FAIL b2b_second_start got=%b exp=011",
                             {bus_if.sout, bus_if.need_data, bus_if.busy});
                end
            end
        end
        tick();
        checks++;
        if ({bus_if.done, bus_if.busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_end got=%b exp=10", {bus_if.done, bus_if.busy});
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL b2b_frame got=none exp=%h", want);
            end else begin
                got = rx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL b2b_frame got=%h exp=%h", got, want);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [8:0] want, got;
        exp_q.push_back({1'b1, 8'h22});
        write_byte(8'h11);
        write_byte(8'h22);
        repeat (11) tick();
        exp_q.push_back({1'b1, 8'h44});
        exp_q.push_back({1'b1, 8'h33});
        write_byte(8'h44);
        tick_wr(8'h33);
        checks++;
        if ({bus_if.need_data, bus_if.sout, bus_if.done} !== 3'b100) begin
            errors++;
            $display("FAIL coll_xfer_wr got=%b exp=100", {bus_if.need_data, bus_if.sout, bus_if.done});
        end
        repeat (9) tick();
        tick();
        checks++;
        if ({bus_if.need_data, bus_if.sout} !== 2'b10) begin
            errors++;
            $display("FAIL coll_second_start got=%b exp=10", {bus_if.need_data, bus_if.sout});
        end
        repeat (10) tick();
        exp_q.push_back({1'b1, 8'h5A});
        tick_wr(8'h5A);
        checks++;
        if ({bus_if.sout, bus_if.busy, bus_if.done, bus_if.need_data} !== 4'b1000) begin
            errors++;
            $display("FAIL coll_idle_wr_tick got=%b exp=1000",
                     {bus_if.sout, bus_if.busy, bus_if.done, bus_if.need_data});
        end
        tick();
        checks++;
        if ({bus_if.sout, bus_if.need_data} !== 2'b01) begin
            errors++;
            $display("FAIL coll_late_start got=%b exp=01", {bus_if.sout, bus_if.need_data});
        end
        repeat (10) tick();
        checks++;
        if (bus_if.done !== 1'b1) begin
            errors++;
            $display("FAIL coll_done got=%b exp=1", bus_if.done);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL coll_frame got=none exp=%h", want);
            end else begin
                got = rx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL coll_frame got=%h exp=%h", got, want);
                end
            end
        end
    endtask

    task automatic test_enp();
        logic [8:0] want, got;
        bus_if.enp      = 1'b0;
        bus_if.wr       = 1'b1;
        bus_if.din      = 8'hC3;
        bus_if.bit_tick = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.wr       = 1'b0;
        bus_if.bit_tick = 1'b0;
        checks++;
        if ({bus_if.done, bus_if.busy, bus_if.sout} !== 3'b101) begin
            errors++;
            $display("FAIL enp_gated_write got=%b exp=101", {bus_if.done, bus_if.busy, bus_if.sout});
        end
        bus_if.enp = 1'b1;
        exp_q.push_back({1'b1, 8'h3C});
        write_byte(8'h3C);
        tick();
        bus_if.enp      = 1'b0;
        bus_if.bit_tick = 1'b1;
        repeat (5) @(negedge clk);
        bus_if.bit_tick = 1'b0;
        checks++;
        if ({bus_if.sout, bus_if.busy} !== 2'b01) begin
            errors++;
            $display("FAIL enp_hold got=%b exp=01", {bus_if.sout, bus_if.busy});
        end
        bus_if.enp = 1'b1;
        repeat (10) tick();
        checks++;
        if (bus_if.done !== 1'b1) begin
            errors++;
            $display("FAIL enp_done got=%b exp=1", bus_if.done);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL enp_frame got=none exp=%h", want);
            end else begin
                got = rx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL enp_frame got=%h exp=%h", got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int nd0;
        write_byte(8'h0F);
        repeat (5) tick();
        checks++;
        if (bus_if.sout !== 1'b1) begin
            errors++;
            $display("FAIL mid_bit3 got=%b exp=1", bus_if.sout);
        end
        write_byte(8'h77);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.sout, bus_if.done, bus_if.busy, bus_if.need_data} !== 4'b1100) begin
            errors++;
            $display("FAIL mid_async_reset got=%b exp=1100",
                     {bus_if.sout, bus_if.done, bus_if.busy, bus_if.need_data});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd0 = nd_count;
        repeat (15) tick();
        checks++;
        if ({bus_if.done, bus_if.busy} !== 2'b10 || rx_q.size() != 0 || nd_count != nd0) begin
            errors++;
            $display("FAIL mid_after_release got done/busy=%b frames=%0d nd=%0d exp 10/0/0",
                     {bus_if.done, bus_if.busy}, rx_q.size(), nd_count - nd0);
        end
    endtask

`ifdef POKEY_SEROUT_BREAK_EN
    task automatic test_break();
        logic [8:0] want, got;
        exp_q.push_back({1'b1, 8'hF3});
        write_byte(8'hFF);
        repeat (3) tick();
        bus_if.force_break = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_if.sout, bus_if.busy} !== 2'b01) begin
            errors++;
            $display("FAIL brk_assert got=%b exp=01", {bus_if.sout, bus_if.busy});
        end
        repeat (2) tick();
        checks++;
        if (bus_if.sout !== 1'b0) begin
            errors++;
            $display("FAIL brk_hold got=%b exp=0", bus_if.sout);
        end
        bus_if.force_break = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_if.sout !== 1'b1) begin
            errors++;
            $display("FAIL brk_resume got=%b exp=1", bus_if.sout);
        end
        repeat (5) tick();
        checks++;
        if ({bus_if.done, bus_if.sout} !== 2'b01) begin
            errors++;
            $display("FAIL brk_stop got=%b exp=01", {bus_if.done, bus_if.sout});
        end
        tick();
        checks++;
        if (bus_if.done !== 1'b1) begin
            errors++;
            $display("FAIL brk_done got=%b exp=1", bus_if.done);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (rx_q.size() == 0) begin
                errors++;
                $display("FAIL brk_frame got=none exp=%h", want);
            end else begin
                got = rx_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL brk_frame got=%h exp=%h", got, want);
                end
            end
        end
    endtask
`endif

    initial begin
        bus_if.enp      = 1'b1;
        bus_if.bit_tick = 1'b0;
        bus_if.wr       = 1'b0;
        bus_if.din      = 8'h00;
`ifdef POKEY_SEROUT_BREAK_EN
        bus_if.force_break = 1'b0;
`endif
        test_reset();
        test_single();
        test_back_to_back();
        test_collision();
        test_enp();
        test_reset_mid();
`ifdef POKEY_SEROUT_BREAK_EN
        test_break();
`endif
        checks++;
        if (nd_bad != 0) begin
            errors++;
            $display("FAIL need_data_alignment got=%0d stray pulses exp=0", nd_bad);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pokey_serout_tx.md
# pokey_serout_tx

Serial output transmitter for the POKEY serial port: the transmit-side counterpart of the serial-input shift chain. It accepts a byte written to the SEROUT register into a holding register, moves it into a shift register at the next bit tick, and emits an asynchronous frame (start bit, 8 data bits LSB-first, stop bit) on the serial output line. It raises the serial-output-needed and transmission-complete interrupt sources.

## Interface
- No parameters; the frame format is fixed at 1 start, 8 data, 1 stop.
- clk  input  1  system clock; every flop updates only on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- enp  input  1  clock-phase enable; all state, including the capture of wr and bit_tick, updates only on edges where enp=1.
- bit_tick  input  1  one-cycle bit-time strobe from the serial clock timer, qualified by enp.
- wr  input  1  SEROUT register write strobe, qualified by enp.
- din  input  8  byte to transmit, sampled when wr=1.
- force_break  input  1  SKCTL force-break; present only with POKEY_SEROUT_BREAK_EN.
- sout  output  1  serial line, registered, idles at 1.
- need_data  output  1  one-enp-cycle pulse when the holding register transfers to the shifter (SEROR source).
- done  output  1  level: shifter idle AND holding register empty (SEROC source).
- busy  output  1  level: FSM not in IDLE.

## Operation
- State: 8-bit holding register with a hold_full flag; 8-bit shift register; 3-bit bit counter; FSM with states IDLE, START, DATA and STOP.
- Write (wr=1, enp=1): hold <= din and hold_full <= 1. A write while hold_full=1 overwrites the holding data silently; no error is flagged.
- Transfer happens on the first bit_tick (in IDLE, or at the end of STOP) where hold_full was already 1 before that cycle:
  - shreg <= hold
  - hold_full <= 0
  - need_data pulses
  - the FSM enters START and sout <= 0.
- START, on a tick: enter DATA, sout <= shreg[0], shift right, cnt <= 0.
- DATA, on a tick:
  - if cnt < 7: sout <= shreg[0], shift, cnt++.
  - if cnt == 7: enter STOP, sout <= 1.
- STOP, on a tick: if hold_full, perform the transfer (back-to-back frame, no idle gap). Otherwise enter IDLE with sout = 1.
- wr and a transfer in the same cycle: the shifter takes the OLD hold contents, hold takes din, and hold_full ends at 1 (the write wins).
- wr and a tick in the same cycle while IDLE with hold_full=0: the byte is captured, but the frame starts no earlier than the next tick.
- No bit_tick means no progress: the FSM holds state indefinitely and sout holds its value.
- done = (state==IDLE) && !hold_full. It is registered and updates in the same cycle as state and hold_full.

## Timing
- Reset values: sout=1, need_data=0, done=1, busy=0, hold_full=0, state IDLE, shreg=0, cnt=0.
- Reset asserted mid-frame aborts immediately (asynchronously): sout returns to 1 and the pending byte is discarded.
- Every output changes only on a clk edge with enp=1.
- sout transitions occur on the edge where the bit_tick is sampled.
- Frame length is exactly 10 bit_tick intervals.
- Latency: a write at tick-interval k produces the start bit at the first tick after the write cycle.
- need_data is high for exactly one enp-qualified cycle, coincident with the start-bit edge.
- busy rises with the start bit and falls at the tick that ends the stop bit when no byte is pending.

## Configuration
- Macro: POKEY_SEROUT_BREAK_EN.
- Defined:
  - the force_break port exists.
  - while force_break=1, sout is driven to 0 on the next enp edge.
  - the FSM, shifter, interrupts and busy continue unaffected.
  - when force_break deasserts, sout shows the current FSM bit on the next enp edge.
- Undefined: the port and its logic are absent, and sout is purely FSM-driven.

## Test plan
- Reset then idle: hold rst_n low, release, run 50 ticks with no writes -> sout=1, done=1, busy=0, need_data never pulses.
- Single byte 0xA5: write, then ticks -> sout sequence 0,1,0,1,0,0,1,0,1,1 over 10 ticks; need_data pulses once at the start edge; done returns to 1 after the stop tick.
- Back-to-back: write 0x00, then write 0xFF after need_data -> two contiguous frames with no idle bit between the stop and the next start; done stays 0 until the second stop ends.
- Collision and overwrite:
  - write 0x11, then 0x22 before any tick -> frame carries 0x22.
  - write 0x33 in the same cycle as the transfer tick of a pending 0x44 -> 0x44 is sent first, then 0x33.
- Reset mid-frame: assert rst_n low after data bit 3 of 0x0F -> sout=1, done=1, busy=0 immediately; no further frame after release.
- Break (macro defined): assert force_break during data bits of 0xFF -> sout=0 while asserted; after release, sout resumes on the correct bit; frame timing is unchanged.
